// File: rtl/uart_mmio_fifo_if.sv
// rtl/uart_mmio_fifo_if.sv - CPU data-port bus into the UART MMIO window
interface uart_mmio_fifo_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] bus_addr;
  logic [XLEN-1:0] bus_wdata;
  logic            bus_we;
  logic            bus_rd;
  logic            bus_sel;
  logic [XLEN-1:0] bus_rdata;

  modport master (
    output bus_addr, bus_wdata, bus_we, bus_rd,
    input  bus_sel, bus_rdata
  );

  modport slave (
    input  bus_addr, bus_wdata, bus_we, bus_rd,
    output bus_sel, bus_rdata
  );
endinterface

// File: rtl/uart_mmio_fifo.sv
// rtl/uart_mmio_fifo.sv - memory-mapped UART front end with RX/TX byte FIFOs
module uart_mmio_fifo #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH_LOG2 = 4,
  parameter logic [XLEN-1:0] BASE       = 32'h00021000
) (
  input  logic             clk,
  input  logic             reset,
  uart_mmio_fifo_if.slave  bus,
  output logic [7:0]       tx_data,
  output logic             tx_data_valid,
  input  logic             tx_data_ack,
  input  logic [7:0]       rx_data,
  input  logic             rx_data_fresh,
  output logic             irq
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, SEND} tx_state_t;

  logic [7:0]    rx_mem [DEPTH];
  logic [7:0]    tx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr, rx_rd_ptr, tx_wr_ptr, tx_rd_ptr;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_overrun, tx_overflow;
  logic [1:0]    ctrl;
  tx_state_t     state, state_next;

  logic          sel;
  logic [1:0]    reg_idx;
  logic          rx_empty, rx_full, tx_empty, tx_full, tx_idle;
  logic          rx_pop, rx_push, rx_drop;
  logic          tx_req, tx_pop, tx_push, tx_drop;
  logic          status_wr, ctrl_wr;
  logic [XLEN-1:0] rdata;
  logic          unused_bits;

  assign sel     = bus.bus_addr[XLEN-1:4] == BASE[XLEN-1:4];
  assign reg_idx = bus.bus_addr[3:2];
  assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[XLEN-1:8]};

  assign rx_empty = rx_count == '0;
  assign rx_full  = rx_count == CW'(DEPTH);
  assign tx_empty = tx_count == '0;
  assign tx_full  = tx_count == CW'(DEPTH);
  assign tx_idle  = tx_empty && (state == IDLE);

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push
  assign rx_pop  = bus.bus_rd && sel && (reg_idx == 2'd0) && !rx_empty;
  assign rx_push = rx_data_fresh && (!rx_full || rx_pop);
  assign rx_drop = rx_data_fresh && rx_full && !rx_pop;

  assign tx_req  = bus.bus_we && sel && (reg_idx == 2'd0);
  assign tx_pop  = (state == SEND) && tx_data_ack;
  assign tx_push = tx_req && (!tx_full || tx_pop);
  assign tx_drop = tx_req && tx_full && !tx_pop;

  assign status_wr = bus.bus_we && sel && (reg_idx == 2'd1);
  assign ctrl_wr   = bus.bus_we && sel && (reg_idx == 2'd2);

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    if (tx_push) tx_mem[tx_wr_ptr] <= bus.bus_wdata[7:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wr_ptr   <= '0;
      rx_rd_ptr   <= '0;
      rx_count    <= '0;
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_count    <= '0;
      rx_overrun  <= 1'b0;
      tx_overflow <= 1'b0;
      ctrl        <= 2'b00;
      irq         <= 1'b0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      if (rx_push && !rx_pop)      rx_count <= rx_count + CW'(1);
      else if (!rx_push && rx_pop) rx_count <= rx_count - CW'(1);

      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      if (tx_push && !tx_pop)      tx_count <= tx_count + CW'(1);
      else if (!tx_push && tx_pop) tx_count <= tx_count - CW'(1);

      // Set has priority over a write-1-to-clear in the same cycle
      if (rx_drop)                                rx_overrun <= 1'b1;
      else if (status_wr && bus.bus_wdata[3])     rx_overrun <= 1'b0;
      if (tx_drop)                                tx_overflow <= 1'b1;
      else if (status_wr && bus.bus_wdata[4])     tx_overflow <= 1'b0;

      if (ctrl_wr) ctrl <= bus.bus_wdata[1:0];
      irq <= (ctrl[0] && !rx_empty) || (ctrl[1] && tx_idle);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    tx_data_valid = 1'b0;
    tx_data       = 8'h00;
    case (state)
      IDLE: if (!tx_empty) state_next = SEND;
      SEND: begin
        tx_data_valid = 1'b1;
        tx_data       = tx_mem[tx_rd_ptr];
        if (tx_data_ack && (tx_count == CW'(1)) && !tx_push) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      case (reg_idx)
        2'd0: begin
          rdata[XLEN-1] = rx_empty;
          rdata[7:0]    = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];
        end
        2'd1: begin
          rdata[0]       = !rx_empty;
          rdata[1]       = tx_full;
          rdata[2]       = tx_idle;
          rdata[3]       = rx_overrun;
          rdata[4]       = tx_overflow;
          rdata[8 +: CW]  = rx_count;
          rdata[16 +: CW] = tx_count;
        end
        2'd2: rdata[1:0] = ctrl;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.bus_sel   = sel;
  assign bus.bus_rdata = rdata;
endmodule
